spi_flash_burst_reader: RTL
===========================

Name: spi_flash_burst_reader

Overview:
- Parametrised SPI NOR flash burst reader; successor to the fixed burst-memory stub.
- Issues a READ command, address and N-byte burst, then streams bytes out on a valid/ready interface.
- Sits between the top-level SPI flash pins and the program-load / data-fetch logic, after power-on reset releases.

Parameters:
- ADDR_W, 24, flash address width in bits; must be a multiple of 8, range 8..32.
- LEN_W, 16, width of burst_len; maximum burst is 2^LEN_W-1 bytes.
- SCK_DIV, 2, clk cycles per SCK half-period; must be >= 1.
- CS_IDLE, 4, minimum clk cycles spi_cs_n stays high between transactions.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous reset, active low.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first byte address; latched on accepted start.
- burst_len  in  LEN_W  byte count; latched on accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at end of burst.
- data  out  8  received byte.
- data_valid  out  1  data holds a byte not yet accepted.
- data_ready  in  1  consumer accepts when data_valid && data_ready.
- spi_cs_n  out  1  flash chip select, active low.
- spi_sck  out  1  SPI clock, mode 0 (idle low).
- spi_mosi  out  1  serial out, MSB first.
- spi_miso  in  1  serial in, sampled on SCK rising edge.

Behaviour:
- Reset values: busy=0, done=0, data=0, data_valid=0, spi_cs_n=1, spi_sck=0, spi_mosi=0.
- Reset mid-burst: returns to IDLE on the next edge, CS high immediately. No done pulse.
- States:
  - IDLE: start=1 and burst_len!=0 latches the inputs and moves to CMD with CS low.
  - CMD: shifts 8 opcode bits.
  - ADDR: shifts ADDR_W bits.
  - DUMMY: optional, see Optional Feature.
  - DATA: shifts 8 bits per byte.
  - HOLD: output byte pending, SCK stopped.
  - GAP: CS high for CS_IDLE cycles.
  - Return to IDLE after GAP.
- Zero-length start (start=1, burst_len=0): no SPI activity. busy=1 for exactly one cycle, done pulses the following cycle.
- start while busy: ignored.
- SCK timing: toggles every SCK_DIV clk cycles while in CMD/ADDR/DUMMY/DATA.
  - MOSI changes on falling edges; the first bit is set up as CS falls, at least SCK_DIV cycles before the first rising edge.
  - MISO is captured into the shift register in the same clk cycle as each rising SCK edge.
- Byte output: after the 8th rising edge of a data byte, the byte moves to data and data_valid=1 on the next clk.
- Back-pressure: output is one byte deep plus the shift register.
  - If a byte completes while data_valid is still 1, the FSM enters HOLD with SCK low and CS low.
  - It resumes one SCK_DIV after the handshake.
  - data and data_valid stay stable until accepted.
- Done: after the last byte is shifted, CS rises and GAP begins. done pulses when the last byte is accepted or GAP ends, whichever is later; busy falls in the same cycle.
- Remaining count: LEN_W-bit down-counter with no wrap. Address increment is done by the flash; the block never re-sends the address.

Optional Feature:
- Macro: SPI_FLASH_FAST_READ_EN.
- Defined: opcode 0x0B, followed by 8 DUMMY SCK cycles with MOSI=0 before DATA.
- Undefined: opcode 0x03, DUMMY state absent, ADDR goes directly to DATA.

Decomposition:
- Shared package spi_flash_pkg:
  - State enum.
  - Opcode constants OP_READ=8'h03 and OP_FAST_READ=8'h0B.
  - DUMMY_CYC=8.
- One sub-module, spi_sck_gen: divided SCK generator with enable/stop, producing rise and fall strobes, reset to SCK low.

Test Plan:
- Basic read: SCK_DIV=2, addr=0x001000, len=4, flash model holds A0 A1 A2 A3, data_ready=1.
  - MOSI carries 0x03 and then 0x001000.
  - Four bytes A0..A3 are delivered in order.
  - done pulses once; CS is high for >=4 cycles afterwards.
- Back-pressure: len=3, data_ready=0 for 50 cycles after the first valid.
  - SCK is held low with CS low, and data stays A0.
  - After ready rises, bytes A1 and A2 follow with no loss or duplication.
- Zero length: start with len=0.
  - CS never falls and SCK never toggles.
  - busy is high for 1 cycle; done follows on the next cycle.
- Reset mid-burst: rstn=0 during the ADDR phase for 1 cycle.
  - On the next edge: CS=1, SCK=0, busy=0, no done.
  - A subsequent start at addr 0x000000, len=1 returns flash byte 0.
- Busy start: pulse start again during DATA with a different address.
  - It is ignored, and the original burst completes unchanged.
- Fast read (SPI_FLASH_FAST_READ_EN defined): addr=0x000010, len=2.
  - Opcode 0x0B, then 8 dummy SCK cycles.
  - Flash bytes at 0x10 and 0x11 are returned.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// ---------------------------------------------------------------------------
// spi_flash_pkg
// Shared definitions for the SPI NOR flash burst reader:
//   state_e      - controller FSM states
//   OP_READ      - plain READ opcode (no dummy cycles)
//   OP_FAST_READ - FAST READ opcode (followed by DUMMY_CYC dummy SCK cycles)
//   DUMMY_CYC    - number of dummy SCK cycles for FAST READ
// ---------------------------------------------------------------------------
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_HOLD,
    ST_GAP,
    ST_EMPTY   // zero-length request: one busy cycle, then done
  } state_e;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam int         DUMMY_CYC    = 8;

endpackage

// File: rtl/spi_flash_burst_reader_sck_gen.sv
// ---------------------------------------------------------------------------
// spi_sck_gen
// Divided SPI clock generator (mode 0, idle low).
//   clk, rstn : system clock, synchronous active-low reset
//   en        : run the clock; when low SCK is forced low and the divider
//               restarts, so the first edge after enabling is a rising edge
//               SCK_DIV cycles later
//   sck       : SPI clock
//   rise/fall : high in the cycle whose closing clk edge makes SCK rise/fall
// ---------------------------------------------------------------------------
module spi_sck_gen #(
  parameter int SCK_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          toggle;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cnt_d  = cnt_q;
    sck_d  = sck_q;
    toggle = en && (cnt_q == CW'(SCK_DIV - 1));
    rise   = toggle && !sck_q;
    fall   = toggle && sck_q;

    if (!en) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (toggle) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    if (!rstn) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/spi_flash_burst_reader.sv
// ---------------------------------------------------------------------------
// spi_flash_burst_reader
// Issues a READ (or FAST READ) command plus address to an SPI NOR flash,
// clocks in burst_len bytes and hands them out on a valid/ready interface.
//
// Ports:
//   clk, rstn          system clock, synchronous active-low reset
//   start              one-cycle request, honoured only when idle
//   start_addr         first byte address (latched on accepted start)
//   burst_len          byte count (latched on accepted start), 0 = no-op
//   busy / done        busy from accepted start until the done pulse
//   data / data_valid  received byte, held until data_ready accepts it
//   data_ready         consumer handshake
//   spi_cs_n, spi_sck, spi_mosi, spi_miso   SPI mode 0 flash pins
//
// Configuration macro: SPI_FLASH_FAST_READ_EN
//   defined   -> opcode 0x0B followed by 8 dummy SCK cycles (MOSI low)
//   undefined -> opcode 0x03, address goes straight to data
// ---------------------------------------------------------------------------
module spi_flash_burst_reader
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 16,
  parameter int SCK_DIV = 2,
  parameter int CS_IDLE = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic [7:0]        data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = OP_FAST_READ;
`else
  localparam logic [7:0] OPCODE = OP_READ;
`endif

  localparam int TX_W = 8 + ADDR_W;
  localparam int GW   = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  state_e            state_q, state_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;   // rising SCK edges within the phase
  logic [TX_W-1:0]   tx_q, tx_d;             // opcode+address, MSB drives MOSI
  logic [7:0]        rx_q, rx_d;
  logic              rx_full_q, rx_full_d;   // rx_q holds a complete byte
  logic [LEN_W-1:0]  rem_q, rem_d;           // bytes still to be shifted in
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [7:0]        data_q, data_d;
  logic              data_valid_q, data_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;

  logic sck_en, sck_rise, sck_fall;
  logic xfer, drained;

  assign sck_en = (state_q == ST_CMD)   || (state_q == ST_ADDR) ||
                  (state_q == ST_DUMMY) || (state_q == ST_DATA);

  spi_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
    .clk  (clk),
    .rstn (rstn),
    .en   (sck_en),
    .sck  (spi_sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rx_full_d    = rx_full_q;
    rem_d        = rem_q;
    gap_cnt_d    = gap_cnt_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cs_n_d       = cs_n_q;

    // Output stage: a completed byte moves into the output register as soon
    // as that register is empty or being emptied by the current handshake.
    xfer    = rx_full_q && (!data_valid_q || data_ready);
    drained = !rx_full_q && (!data_valid_q || data_ready);

    if (data_valid_q && data_ready) data_valid_d = 1'b0;
    if (xfer) begin
      data_d       = rx_q;
      data_valid_d = 1'b1;
      rx_full_d    = 1'b0;
    end

    // MOSI advances on falling SCK; zeros shift in behind the address, which
    // also keeps MOSI low through the dummy and data phases.
    if (sck_fall) tx_d = {tx_q[TX_W-2:0], 1'b0};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (burst_len != '0) begin
            state_d   = ST_CMD;
            cs_n_d    = 1'b0;
            tx_d      = {OPCODE, start_addr};
            rem_d     = burst_len;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end

      ST_EMPTY: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      ST_CMD: begin
        if (sck_rise) begin
          if (bit_cnt_q == 6'd7) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end

      ST_ADDR: begin
        if (sck_rise) begin
          if (bit_cnt_q == 6'(ADDR_W - 1)) begin
`ifdef SPI_FLASH_FAST_READ_EN
            state_d = ST_DUMMY;
`else
            state_d = ST_DATA;
`endif
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end

`ifdef SPI_FLASH_FAST_READ_EN
      ST_DUMMY: begin
        if (sck_rise) begin
          if (bit_cnt_q == 6'(DUMMY_CYC - 1)) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
`endif

      ST_DATA: begin
        if (sck_rise) begin
          rx_d = {rx_q[6:0], spi_miso};
          if (bit_cnt_q == 6'd7) begin
            rx_full_d = 1'b1;
            bit_cnt_d = '0;
            if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else if (sck_fall) begin
          // Phase changes happen on the falling edge so SCK is already low
          // when CS rises or the clock is parked.
          if (rem_q == '0) begin
            state_d   = ST_GAP;
            cs_n_d    = 1'b1;
            gap_cnt_d = '0;
          end else if (rx_full_q && !xfer) begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // Re-enabling the divider yields the next rise SCK_DIV cycles later.
        if (xfer) state_d = ST_DATA;
      end

      ST_GAP: begin
        if (gap_cnt_q == GW'(CS_IDLE - 1)) begin
          if (drained) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      rx_full_q    <= 1'b0;
      rem_q        <= '0;
      gap_cnt_q    <= '0;
      // NOTE: the data path registers are reset too because data and MOSI
      // are outputs with defined reset values, not just internal storage.
      data_q       <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cs_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      rx_full_q    <= rx_full_d;
      rem_q        <= rem_d;
      gap_cnt_q    <= gap_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cs_n_q       <= cs_n_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_mosi   = tx_q[TX_W-1];

endmodule
